quad_operand_seq: RTL
=====================

QUAD_OPERAND_SEQ -- requirements
Module: quad_operand_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-003 SHALL have port start, input, 1 bit: request to evaluate a*x^2 + b*x + c.
REQ-004 SHALL have ports coef_a, coef_b, coef_c, input, 8 bits each: unsigned coefficients, sampled on an accepted start.
REQ-005 SHALL have port x, input, 8 bits: unsigned operand, sampled on an accepted start.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have ports in_ai and in_xi, output, 8 bits each: operand pair for the downstream multiply-accumulate stage.
REQ-008 SHALL have port last_input, output, 1 bit: marks the final operand pair of a run.
REQ-009 SHALL have port sum_valid, output, 1 bit: one-cycle pulse when the downstream sum is complete.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, SQR, TERM_A, TERM_B, TERM_C and FLUSH.
REQ-011 SHALL accept start only in IDLE, capturing coef_a, coef_b, coef_c and x and moving to SQR; start in any other state SHALL be ignored.
REQ-012 SHALL, in SQR, register xsq = x*x reduced to 8 bits per REQ-022/023.
REQ-013 SHALL step SQR->TERM_A->TERM_B->TERM_C->FLUSH->IDLE unconditionally, one cycle per state.
REQ-014 SHALL drive (in_ai, in_xi) as: TERM_A = (a, xsq); TERM_B = (b, x); TERM_C = (c, 8'd1); all other states = (0, 0).
REQ-015 SHALL assert last_input only in TERM_C.
REQ-016 SHALL assert sum_valid only in FLUSH; the downstream sum is valid in that same cycle.
REQ-017 SHALL hold captured operands constant from acceptance until return to IDLE.
REQ-018 SHALL take exactly 6 cycles per run; a start held high in FLUSH SHALL NOT be accepted, and a start high in the next (IDLE) cycle SHALL be accepted, giving one back-to-back run per 6 cycles.
REQ-019 SHALL drive every output from registers or a state decode only, with no combinational path from any input.

Reset
REQ-020 SHALL, when reset is low, force IDLE immediately and set all outputs to 0: busy=0, in_ai=0, in_xi=0, last_input=0, sum_valid=0; captured operands and xsq SHALL clear to 0.
REQ-021 SHALL abandon any run in progress when reset is asserted mid-run, with no sum_valid pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-022 SHALL, with QUAD_SQ_SAT_EN defined, saturate xsq to 8'hFF whenever x*x > 255.
REQ-023 SHALL, without QUAD_SQ_SAT_EN, truncate xsq to the low 8 bits of x*x.

Structure
REQ-024 SHALL import the following from shared package quad_mac_pkg: the state enum (IDLE..FLUSH), the OPW=8 operand-width constant, and the ACCW=16 accumulator-width constant.
REQ-025 SHALL place the squaring and reduction logic in sub-module quad_square_sat, which holds the QUAD_SQ_SAT_EN conditional.

Verification
REQ-026 SHALL cover a basic run: a=2, b=3, c=4, x=5, start=1 -> pairs (2,25), (3,5), (4,1) in cycles 2-4, last_input in cycle 4, sum_valid in cycle 5, downstream sum = 69.
REQ-027 SHALL cover square overflow: x=20, a=1, b=0, c=0 -> in_xi=255 in TERM_A with QUAD_SQ_SAT_EN, and 144 without it.
REQ-028 SHALL cover start during a run: start re-pulsed with a=9 while busy -> ignored, current run's pairs unchanged, exactly one sum_valid.
REQ-029 SHALL cover reset mid-run: reset low during TERM_B -> all outputs 0 immediately, no sum_valid; a new run of a=1, b=1, c=1, x=1 gives sum 3.
REQ-030 SHALL cover back-to-back runs: start held high continuously -> runs begin every 6 cycles, each sum_valid matches its own operands, and the downstream accumulator starts from 0 each run.
REQ-031 SHALL cover the boundary case: all operands 255 with truncation (255*255 = 65025, low byte 1) -> pairs (255,1), (255,255), (255,1), downstream sum = 65535.

Source files
------------

// File: rtl/quad_mac_pkg.sv
// quad_mac_pkg: definitions shared by the quadratic operand sequencer and
// the downstream multiply-accumulate stage.
//   OPW          - operand width for coefficients, x and the reduced square
//   ACCW         - downstream accumulator width; also the full x*x width
//   quad_state_e - sequencer states, IDLE..FLUSH
package quad_mac_pkg;

  localparam int OPW  = 8;
  localparam int ACCW = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQR    = 3'd1,
    TERM_A = 3'd2,
    TERM_B = 3'd3,
    TERM_C = 3'd4,
    FLUSH  = 3'd5
  } quad_state_e;

endpackage

// File: rtl/quad_square_sat.sv
// quad_square_sat: combinational x*x reduced to OPW bits.
// Build option: QUAD_SQ_SAT_EN
//   defined   - any square above 255 clamps to 8'hFF
//   undefined - the square keeps only its low OPW bits
// Ports:
//   x   (in,  OPW) operand to square
//   xsq (out, OPW) reduced square
module quad_square_sat
  import quad_mac_pkg::*;
(
  input  logic [OPW-1:0] x,
  output logic [OPW-1:0] xsq
);

`ifdef QUAD_SQ_SAT_EN
  logic [ACCW-1:0] prod;

  assign prod = ACCW'(x) * ACCW'(x);
  assign xsq  = (prod > ACCW'(255)) ? '1 : prod[OPW-1:0];
`else
  // Evaluated at OPW width, so the multiply discards the high byte itself.
  assign xsq = x * x;
`endif

endmodule

// File: rtl/quad_operand_seq.sv
// quad_operand_seq: steps the operand pairs of a*x^2 + b*x + c into a
// downstream multiply-accumulate stage, one pair per cycle.
// Build option: QUAD_SQ_SAT_EN (passed to quad_square_sat) selects
// saturating instead of truncating reduction of x*x.
// Ports:
//   clk                    rising-edge clock
//   reset                  asynchronous reset, active low
//   start                  run request, accepted only in IDLE
//   coef_a/coef_b/coef_c   coefficients, captured on acceptance
//   x                      operand, captured on acceptance
//   busy                   high in every state other than IDLE
//   in_ai/in_xi            operand pair for the MAC stage
//   last_input             marks the final pair of a run
//   sum_valid              one-cycle pulse, downstream sum complete
//
// state  | meaning
// IDLE   | waiting for start
// SQR    | operands held, x*x registered at the end of this cycle
// TERM_A | present (a, xsq)
// TERM_B | present (b, x)
// TERM_C | present (c, 1), last pair of the run
// FLUSH  | downstream sum valid
module quad_operand_seq
  import quad_mac_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [OPW-1:0] coef_a,
  input  logic [OPW-1:0] coef_b,
  input  logic [OPW-1:0] coef_c,
  input  logic [OPW-1:0] x,
  output logic           busy,
  output logic [OPW-1:0] in_ai,
  output logic [OPW-1:0] in_xi,
  output logic           last_input,
  output logic           sum_valid
);

  quad_state_e    state_q, state_d;
  logic [OPW-1:0] a_q, b_q, c_q, x_q, xsq_q;
  logic [OPW-1:0] xsq_w;
  logic           accept;

  assign accept = (state_q == IDLE) && start;

  quad_square_sat u_square (
    .x   (x_q),
    .xsq (xsq_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands stay frozen from acceptance until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      x_q   <= '0;
      xsq_q <= '0;
    end else begin
      if (accept) begin
        a_q <= coef_a;
        b_q <= coef_b;
        c_q <= coef_c;
        x_q <= x;
      end
      if (state_q == SQR) begin
        xsq_q <= xsq_w;
      end
    end
  end

  // Outputs decode only from state and registered operands.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    in_ai      = '0;
    in_xi      = '0;
    last_input = 1'b0;
    sum_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = SQR;
      end
      SQR: state_d = TERM_A;
      TERM_A: begin
        state_d = TERM_B;
        in_ai   = a_q;
        in_xi   = xsq_q;
      end
      TERM_B: begin
        state_d = TERM_C;
        in_ai   = b_q;
        in_xi   = x_q;
      end
      TERM_C: begin
        state_d    = FLUSH;
        in_ai      = c_q;
        in_xi      = OPW'(1);
        last_input = 1'b1;
      end
      FLUSH: begin
        state_d   = IDLE;
        sum_valid = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

endmodule
